// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and default constants for the stopwatch control block.
//   sw_state_t    : control FSM states (also exported on the debug state port)
//   DW_DEF        : default width of seconds/minutes values
//   SEC_LIMIT_DEF : default seconds modulus (must match the seconds counter)
//   MIN_LIMIT_DEF : default minutes modulus
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_PAUSE = 2'd2,
        SW_CLEAR = 2'd3
    } sw_state_t;

    localparam int DW_DEF        = 6;
    localparam int SEC_LIMIT_DEF = 60;
    localparam int MIN_LIMIT_DEF = 60;

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Free-running modulo-PRESC counter with synchronous clear and count enable.
//   o_tick is high for the single enabled cycle in which the count sits at
//   PRESC-1; the count wraps to 0 on that same edge. When enable is low the
//   count holds, so a partially elapsed period is preserved.
// Ports
//   clk     in  1  system clock
//   rst     in  1  synchronous active-high reset (count -> 0)
//   clear   in  1  synchronous clear (count -> 0), dominates enable
//   enable  in  1  advance the count this cycle
//   o_tick  out 1  terminal-count pulse (combinational from the count)
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int PRESC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic o_tick
);

    localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign o_tick = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control FSM for the stopwatch seconds counter. Derives the per-second tick,
//   drives the external seconds counter (enable level, count pulse, clear),
//   keeps the minutes value (carry out of seconds) and a lap-capture register.
// Ports
//   clk           in  1   system clock
//   rst           in  1   synchronous active-high reset
//   i_btn_start   in  1   start/stop toggle pulse
//   i_btn_reset   in  1   clear stopwatch pulse (wins over start/lap)
//   i_btn_lap     in  1   lap capture pulse (RUN/PAUSE only)
//   i_sec_count   in  DW  current seconds value from the counter
//   o_sw_clk      out 1   counter level enable (low clears counter)
//   o_start_stop  out 1   counter count pulse, 2 cycles per tick
//   o_reset       out 1   counter clear
//   o_min         out DW  minutes, 0..MIN_LIMIT-1
//   o_lap_sec     out DW  captured seconds
//   o_lap_min     out DW  captured minutes
//   o_lap_valid   out 1   1-cycle pulse when lap registers update
//   o_running     out 1   high while in RUN
//   o_dbg_state   out 2   current FSM state
// Handshake: there is no back-pressure anywhere; every button is a one-cycle
//   pulse that is acted on in the cycle it is high, and every output is a
//   registered level or one-shot with fixed timing relative to that cycle.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int SEC_LIMIT = SEC_LIMIT_DEF,
    parameter int MIN_LIMIT = MIN_LIMIT_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_btn_start,
    input  logic          i_btn_reset,
    input  logic          i_btn_lap,
    input  logic [DW-1:0] i_sec_count,
    output logic          o_sw_clk,
    output logic          o_start_stop,
    output logic          o_reset,
    output logic [DW-1:0] o_min,
    output logic [DW-1:0] o_lap_sec,
    output logic [DW-1:0] o_lap_min,
    output logic          o_lap_valid,
    output logic          o_running,
    output sw_state_t     o_dbg_state
);

    localparam int PRESC = CLK_HZ / TICK_HZ;

    sw_state_t     state_q, state_d;
    logic          clr_cnt_q, clr_cnt_d;
    logic          pulse_rem_q, pulse_rem_d;
    logic          sw_clk_q, sw_clk_d;
    logic          start_stop_q, start_stop_d;
    logic          reset_q, reset_d;
    logic          running_q, running_d;
    logic [DW-1:0] min_q, min_d;
    logic [DW-1:0] lap_sec_q, lap_sec_d;
    logic [DW-1:0] lap_min_q, lap_min_d;
    logic          lap_valid_q, lap_valid_d;

    logic presc_clear;
    logic presc_enable;
    logic tick;
    logic going_clear;
    logic lap_take;

    // The prescaler must not advance in the cycle a start (pause) or reset
    // is pressed, so the frozen fraction is the value seen at the button.
    assign presc_clear  = (state_q == SW_IDLE) || (state_q == SW_CLEAR);
    assign presc_enable = (state_q == SW_RUN) && !i_btn_start && !i_btn_reset;

    tick_prescaler #(
        .PRESC (PRESC)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clear  (presc_clear),
        .enable (presc_enable),
        .o_tick (tick)
    );

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            SW_IDLE: begin
                if (i_btn_reset) begin
                    state_d   = SW_CLEAR;
                    clr_cnt_d = 1'b0;
                end else if (i_btn_start) begin
                    state_d = SW_RUN;
                end
            end
            SW_RUN: begin
                if (i_btn_reset) begin
                    state_d   = SW_CLEAR;
                    clr_cnt_d = 1'b0;
                end else if (i_btn_start) begin
                    state_d = SW_PAUSE;
                end
            end
            SW_PAUSE: begin
                if (i_btn_reset) begin
                    state_d   = SW_CLEAR;
                    clr_cnt_d = 1'b0;
                end else if (i_btn_start) begin
                    state_d = SW_RUN;
                end
            end
            SW_CLEAR: begin
                // Two cycles in CLEAR, buttons ignored.
                if (clr_cnt_q) begin
                    state_d = SW_IDLE;
                end else begin
                    clr_cnt_d = 1'b1;
                end
            end
            default: state_d = SW_IDLE;
        endcase
    end

    assign going_clear = (state_d == SW_CLEAR);
    assign lap_take    = i_btn_lap && !i_btn_reset &&
                         ((state_q == SW_RUN) || (state_q == SW_PAUSE));

    // Registered outputs, computed from the next state so they line up with it
    always_comb begin
        sw_clk_d     = (state_d == SW_RUN) || (state_d == SW_PAUSE);
        reset_d      = !sw_clk_d;
        running_d    = (state_d == SW_RUN);

        // Pulse stretcher: tick opens a 2-cycle window, CLEAR kills it.
        start_stop_d = 1'b0;
        pulse_rem_d  = 1'b0;
        if (!going_clear) begin
            if (tick) begin
                start_stop_d = 1'b1;
                pulse_rem_d  = 1'b1;
            end else if (pulse_rem_q) begin
                start_stop_d = 1'b1;
            end
        end

        // Minute carry rises together with the count pulse that wraps seconds.
        min_d = min_q;
        if (going_clear) begin
            min_d = '0;
        end else if (tick && (i_sec_count == DW'(SEC_LIMIT - 1))) begin
            min_d = (min_q == DW'(MIN_LIMIT - 1)) ? '0 : min_q + 1'b1;
        end

        // Lap captures the pre-carry minutes value.
        lap_sec_d   = lap_sec_q;
        lap_min_d   = lap_min_q;
        lap_valid_d = 1'b0;
        if (going_clear) begin
            lap_sec_d = '0;
            lap_min_d = '0;
        end else if (lap_take) begin
            lap_sec_d   = i_sec_count;
            lap_min_d   = min_q;
            lap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SW_IDLE;
            clr_cnt_q    <= 1'b0;
            pulse_rem_q  <= 1'b0;
            sw_clk_q     <= 1'b0;
            start_stop_q <= 1'b0;
            reset_q      <= 1'b1;
            running_q    <= 1'b0;
            min_q        <= '0;
            lap_sec_q    <= '0;
            lap_min_q    <= '0;
            lap_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            pulse_rem_q  <= pulse_rem_d;
            sw_clk_q     <= sw_clk_d;
            start_stop_q <= start_stop_d;
            reset_q      <= reset_d;
            running_q    <= running_d;
            min_q        <= min_d;
            lap_sec_q    <= lap_sec_d;
            lap_min_q    <= lap_min_d;
            lap_valid_q  <= lap_valid_d;
        end
    end

    assign o_sw_clk     = sw_clk_q;
    assign o_start_stop = start_stop_q;
    assign o_reset      = reset_q;
    assign o_min        = min_q;
    assign o_lap_sec    = lap_sec_q;
    assign o_lap_min    = lap_min_q;
    assign o_lap_valid  = lap_valid_q;
    assign o_running    = running_q;
    assign o_dbg_state  = state_q;

endmodule
